// File: rtl/reg_write_tracer.sv
// reg_write_tracer
//   Taps the MIPS register-file write port and PC and records each watched
//   register write as {cycle, pc, addr, data} in a FIFO. The FIFO drains
//   through a valid/ready port. Supports a trigger PC, a per-register watch
//   mask, and a choice between freezing and overwriting when full.
// Ports
//   clk, reset                 core clock (rising edge), async active-high reset
//   arm                        1-cycle pulse: clear FIFO/counters and start a trace
//   trig_en, trig_pc           wait for pc == trig_pc before capturing
//   pc                         PC of the instruction currently writing
//   reg_write, write_address,
//   write_data                 register-file write port tap
//   out_valid, out_ready       head-entry handshake
//   out_cycle/pc/addr/data     head entry fields (0 when empty)
//   count                      entries held (0..DEPTH)
//   dropped                    writes lost to a full FIFO, saturating
//   state                      0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 FROZEN
module reg_write_tracer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CYC_W      = 16,
  parameter logic [31:0] WATCH_MASK = 32'h03FF_FF00,
  parameter bit          OVERWRITE  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic [31:0]              pc,
  input  logic                     reg_write,
  input  logic [4:0]               write_address,
  input  logic [31:0]              write_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              dropped,
  output logic [1:0]               state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_FROZEN    = 2'd3
  } state_e;

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [31:0]      pc;
    logic [4:0]       addr;
    logic [31:0]      data;
  } entry_t;

  state_e           state_q, state_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      dropped_q, dropped_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  entry_t           mem_q [DEPTH];

  logic   watched, pc_match, qual, full, empty, pop, store, lost, wr_en;
  entry_t wr_entry, head_e;

  always_comb begin
    watched  = reg_write && (write_address != '0) && WATCH_MASK[write_address];
    pc_match = (pc == trig_pc);
    qual     = watched && ((state_q == S_CAPTURE) ||
                           ((state_q == S_WAIT_TRIG) && pc_match));
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop      = !empty && out_ready;
    store    = qual && (OVERWRITE || !full);
    // Overwrite mode only loses data when the oldest entry is evicted
    // without being popped; freeze mode loses every watched write once frozen.
    if (OVERWRITE) lost = store && full && !pop;
    else           lost = (qual && full) || ((state_q == S_FROZEN) && watched);
    wr_entry = '{cyc: cyc_q, pc: pc, addr: write_address, data: write_data};

    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    cyc_d     = cyc_q;
    wr_en     = 1'b0;

    if (arm) begin
      state_d   = trig_en ? S_WAIT_TRIG : S_CAPTURE;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      dropped_d = '0;
      cyc_d     = '0;
    end else begin
      wr_en  = store;
      tail_d = tail_q + AW'(store);
      // A store into a full ring evicts the head; with a pop in the same
      // cycle the eviction and the pop are the same single head advance.
      head_d = head_q + AW'(pop || (store && full));
      count_d = count_q + CW'(store && !pop && !full) - CW'(pop && !store);
      if (lost && (dropped_q != '1)) dropped_d = dropped_q + 16'd1;
      if (state_q != S_IDLE) cyc_d = cyc_q + CYC_W'(1);
      if ((state_q == S_WAIT_TRIG) && pc_match) state_d = S_CAPTURE;
      if (!OVERWRITE && (state_d == S_CAPTURE) && (count_d == CW'(DEPTH)))
        state_d = S_FROZEN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      cyc_q     <= cyc_d;
    end
  end

  // Storage needs no reset: every output read from it is gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= wr_entry;
  end

  always_comb begin
    head_e    = mem_q[head_q];
    out_valid = !empty;
    out_cycle = empty ? '0 : head_e.cyc;
    out_pc    = empty ? '0 : head_e.pc;
    out_addr  = empty ? '0 : head_e.addr;
    out_data  = empty ? '0 : head_e.data;
    count     = count_q;
    dropped   = dropped_q;
    state     = state_q;
  end

endmodule
